tdm_mux_scan: RTL and testbench

Parametrised N-channel, W-bit multiplexer with a registered output and a valid/ready output handshake. It is the clocked successor to the 8:1 combinational mux and supports two modes. In MANUAL mode, an external select picks the channel. In SCAN mode, an internal round-robin pointer visits each channel for a programmable dwell. It sits between the per-channel data sources and a single downstream consumer.

---
 rtl/tdm_mux_pkg.sv | 19 +
 rtl/tdm_mux_scan_ptr.sv | 55 +++++
 rtl/tdm_mux_scan.sv | 96 +++++++++
 tb/tb_tdm_mux_scan.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_mux_pkg.sv
// Shared types and defaults for the TDM scanning multiplexer.
// Optional macro TDM_MUX_SKIP_EN enables skipping invalid channels in SCAN mode.
package tdm_mux_pkg;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

   localparam int NCH_DEF   = 8;
   localparam int DW_DEF    = 8;
   localparam int DWELL_DEF = 4;

   // Width helper that never returns zero, so 1- and 2-entry spaces still get a bit
   function automatic int clog2_safe(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tdm_mux_scan_ptr.sv
// Round-robin channel pointer with per-channel dwell counter.
// With TDM_MUX_SKIP_EN defined, a channel with no valid data ends its slot at once.
module tdm_scan_ptr
   import tdm_mux_pkg::*;
#(
   parameter int NCH   = NCH_DEF,
   parameter int DWELL = DWELL_DEF,
   parameter int SW    = clog2_safe(NCH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          clr,
   input  logic          cur_valid,
   output logic [SW-1:0] ptr
);

   localparam int CW = clog2_safe(DWELL);
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
   localparam logic [SW-1:0] PTR_LAST = SW'(NCH - 1);

   logic [CW-1:0] cnt;
   logic [SW-1:0] ptr_nxt;
   logic          slot_end;

   // Explicit wrap keeps non-power-of-2 channel counts in range
   assign ptr_nxt = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;

`ifdef TDM_MUX_SKIP_EN
   assign slot_end = (cnt == CNT_LAST) || !cur_valid;
`else
   logic unused_cur_valid;
   assign unused_cur_valid = cur_valid;
   assign slot_end = (cnt == CNT_LAST);
`endif

   // Pointer and dwell counter advance only on scan load cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
         cnt <= '0;
      end else if (clr) begin
         ptr <= '0;
         cnt <= '0;
      end else if (en) begin
         if (slot_end) begin
            cnt <= '0;
            ptr <= ptr_nxt;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tdm_mux_scan.sv
// N-channel registered mux with MANUAL select and round-robin SCAN modes.
// Optional macro TDM_MUX_SKIP_EN (handled in tdm_scan_ptr) skips invalid channels.
module tdm_mux_scan
   import tdm_mux_pkg::*;
#(
   parameter int NCH   = NCH_DEF,
   parameter int DW    = DW_DEF,
   parameter int DWELL = DWELL_DEF,
   parameter int SW    = clog2_safe(NCH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH*DW-1:0] din,
   input  logic [NCH-1:0]    in_valid,
   input  logic              mode,
   input  logic [SW-1:0]     sel,
   input  logic              out_ready,
   output logic [DW-1:0]     out_data,
   output logic [SW-1:0]     out_ch,
   output logic              out_valid,
   output logic              sel_err
);

   localparam logic [SW:0] NCH_W = (SW + 1)'(NCH);

   mode_e         state;
   mode_e         state_nxt;
   logic          load;
   logic          scan;
   logic          clr;
   logic          sel_ok;
   logic          hit;
   logic [SW-1:0] idx;
   logic [SW-1:0] ptr;

   assign load   = !out_valid || out_ready;
   assign scan   = (state == MODE_SCAN);
   assign sel_ok = ({1'b0, sel} < NCH_W);
   assign idx    = scan ? ptr : (sel_ok ? sel : '0);
   assign hit    = (scan || sel_ok) && in_valid[idx];

   // Mode state register; mode is sampled every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= MODE_MANUAL;
      else        state <= state_nxt;
   end

   // Next state; entering SCAN restarts the pointer at channel 0
   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      case (state)
         MODE_MANUAL: begin
            if (mode) begin
               state_nxt = MODE_SCAN;
               clr       = 1'b1;
            end
         end
         MODE_SCAN: begin
            if (!mode) state_nxt = MODE_MANUAL;
         end
         default: state_nxt = MODE_MANUAL;
      endcase
   end

   tdm_scan_ptr #(
      .NCH   (NCH),
      .DWELL (DWELL),
      .SW    (SW)
   ) u_ptr (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (load && scan),
      .clr       (clr),
      .cur_valid (hit),
      .ptr       (ptr)
   );

   // Output register; held while a sample waits for the consumer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         sel_err   <= 1'b0;
      end else if (load) begin
         out_valid <= hit;
         if (hit) begin
            out_data <= din[idx*DW +: DW];
            out_ch   <= idx;
         end
         if (!scan && !sel_ok) sel_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tdm_mux_scan.sv
// Self-checking bench for tdm_mux_scan (NCH=8 and NCH=5 instances).
// Compares both instances against a slot-arithmetic model every cycle.
module tb_tdm_mux_scan;

   localparam int DWELL = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] din;
   logic [7:0]  in_valid;
   logic        mode;
   logic [2:0]  sel;
   logic        out_ready;
   logic        run;

   logic [7:0]  o8_data, o5_data;
   logic [2:0]  o8_ch, o5_ch;
   logic        o8_valid, o5_valid;
   logic        o8_err, o5_err;

   int checks = 0;
   int errors = 0;

   // model state, index 0 = NCH 8, index 1 = NCH 5
   logic       mv[2];
   logic [7:0] md[2];
   int         mc[2];
   logic       me[2];
   int         mst[2];
   int         mloads[2];
   int         mptr[2];
   int         mcnt[2];

   always #5 clk = ~clk;

   tdm_mux_scan #(.NCH(8), .DW(8), .DWELL(DWELL)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .in_valid  (in_valid),
      .mode      (mode),
      .sel       (sel),
      .out_ready (out_ready),
      .out_data  (o8_data),
      .out_ch    (o8_ch),
      .out_valid (o8_valid),
      .sel_err   (o8_err)
   );

   tdm_mux_scan #(.NCH(5), .DW(8), .DWELL(DWELL)) u_dut5 (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din[39:0]),
      .in_valid  (in_valid[4:0]),
      .mode      (mode),
      .sel       (sel),
      .out_ready (out_ready),
      .out_data  (o5_data),
      .out_ch    (o5_ch),
      .out_valid (o5_valid),
      .sel_err   (o5_err)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_din(input logic [7:0] base);
      for (int k = 0; k < 8; k++) din[k*8 +: 8] = base + 8'(k);
   endtask

   // One clock of the model: channel chosen from slot number, not from counters
   task automatic step(input int i, input int n);
      int p;
      if (!mv[i] || out_ready) begin
         if (mst[i] == 0) begin
            if (int'(sel) < n) begin
               mv[i] = in_valid[sel];
               if (in_valid[sel]) begin
                  md[i] = din[int'(sel)*8 +: 8];
                  mc[i] = int'(sel);
               end
            end else begin
               mv[i] = 1'b0;
               me[i] = 1'b1;
            end
         end else begin
`ifdef TDM_MUX_SKIP_EN
            p = mptr[i];
            if (!in_valid[p] || mcnt[i] == DWELL - 1) begin
               mcnt[i] = 0;
               mptr[i] = (p + 1) % n;
            end else begin
               mcnt[i]++;
            end
`else
            p = (mloads[i] / DWELL) % n;
            mloads[i]++;
`endif
            mv[i] = in_valid[p];
            if (in_valid[p]) begin
               md[i] = din[p*8 +: 8];
               mc[i] = p;
            end
         end
      end
      if (mode && mst[i] == 0) begin
         mloads[i] = 0;
         mptr[i]   = 0;
         mcnt[i]   = 0;
      end
      mst[i] = int'(mode);
   endtask

   // Model advances with the DUT clock and resets with it
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mv[i] = 0; md[i] = 0; mc[i] = 0; me[i] = 0;
            mst[i] = 0; mloads[i] = 0; mptr[i] = 0; mcnt[i] = 0;
         end
      end else begin
         step(0, 8);
         step(1, 5);
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (run) begin
         chk("u8_valid", o8_valid, mv[0]);
         chk("u8_err", o8_err, me[0]);
         if (mv[0]) begin
            chk("u8_data", o8_data, md[0]);
            chk("u8_ch", o8_ch, mc[0]);
         end
         chk("u5_valid", o5_valid, mv[1]);
         chk("u5_err", o5_err, me[1]);
         if (mv[1]) begin
            chk("u5_data", o5_data, md[1]);
            chk("u5_ch", o5_ch, mc[1]);
         end
      end
   end

   logic [15:0] bp;

   initial begin
      run = 0; rst_n = 0; mode = 0; sel = 0;
      out_ready = 1; in_valid = '1; din = '0;
      set_din(8'h10);
      repeat (2) @(negedge clk);
      chk("rst_valid", o8_valid, 0);
      chk("rst_data", o8_data, 0);
      chk("rst_err", o5_err, 0);
      run = 1; rst_n = 1;

      // MANUAL sweep
      for (int k = 0; k < 8; k++) begin
         sel = 3'(k);
         @(negedge clk);
         chk("sweep_data", o8_data, 8'h10 + 8'(k));
         chk("sweep_ch", o8_ch, k);
         chk("sweep_valid", o8_valid, 1);
         if (k == 6) begin
            chk("n5_oor_valid", o5_valid, 0);
            chk("n5_oor_err", o5_err, 1);
         end
      end
      sel = 2;
      @(negedge clk);
      chk("n5_back_valid", o5_valid, 1);
      chk("n5_back_data", o5_data, 8'h12);
      chk("n5_err_sticky", o5_err, 1);

      // back-pressure
      sel = 3;
      @(negedge clk);
      out_ready = 0;
      for (int i = 0; i < 5; i++) begin
         din[3*8 +: 8] = 8'hA0 + 8'(i);
         @(negedge clk);
         chk("bp_hold_data", o8_data, 8'h13);
         chk("bp_hold_ch", o8_ch, 3);
      end
      out_ready = 1;
      @(negedge clk);
      chk("bp_release", o8_data, 8'hA4);
      set_din(8'h10);

      // SCAN, all valid
      mode = 1;
      @(negedge clk);
      for (int j = 0; j < 41; j++) begin
         @(negedge clk);
         if (j == 0)  chk("scan_j0", o8_ch, 0);
         if (j == 3)  chk("scan_j3", o8_ch, 0);
         if (j == 4)  chk("scan_j4", o8_ch, 1);
         if (j == 31) chk("scan_j31", o8_ch, 7);
         if (j == 32) chk("scan_wrap8", o8_ch, 0);
         if (j == 19) chk("scan5_j19", o5_ch, 4);
         if (j == 20) chk("scan_wrap5", o5_ch, 0);
      end

      // SCAN with odd channels valid
      mode = 0;
      repeat (2) @(negedge clk);
      in_valid = 8'hAA;
      mode = 1;
      @(negedge clk);
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
`ifdef TDM_MUX_SKIP_EN
         if (j == 0) chk("skip_j0", o8_valid, 0);
         if (j == 1) chk("skip_j1", o8_ch, 1);
         if (j == 5) chk("skip_j5", o8_valid, 0);
         if (j == 6) chk("skip_j6", o8_ch, 3);
`else
         if (j == 0) chk("gap_j0", o8_valid, 0);
         if (j == 3) chk("gap_j3", o8_valid, 0);
         if (j == 4) chk("gap_j4", o8_ch, 1);
`endif
      end

      // back-pressure while scanning
      in_valid = '1;
      bp = 16'b1011_0010_1100_0110;
      for (int j = 0; j < 16; j++) begin
         out_ready = bp[j];
         @(negedge clk);
      end
      out_ready = 1;

      // async reset mid-scan
      sel = 2;
      repeat (2) @(negedge clk);
      chk("pre_rst_valid", o8_valid, 1);
      #3 rst_n = 0;
      #1;
      chk("arst_valid8", o8_valid, 0);
      chk("arst_data8", o8_data, 0);
      chk("arst_ch8", o8_ch, 0);
      chk("arst_valid5", o5_valid, 0);
      chk("arst_err5", o5_err, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("post_rst_manual", o8_ch, 2);
      chk("post_rst_data", o8_data, 8'h12);
      @(negedge clk);
      chk("post_rst_ptr0", o8_ch, 0);
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
